// File: rtl/controller_sequencer.sv
// SAP-1 controller-sequencer: falling-edge T1..T6 ring counter, opcode decoder and sticky halt.
// Optional CTRL_SKIP_NOP_EN: return to T1 right after the last active micro-step.
module controller_sequencer (
   input  logic        CLK,
   input  logic        CLR,
   input  logic [3:0]  opcode,
   output logic [5:0]  T,
   output logic [11:0] CON,
   output logic        HLT
);

   typedef enum logic [5:0] {
      S_T1 = 6'b000001,
      S_T2 = 6'b000010,
      S_T3 = 6'b000100,
      S_T4 = 6'b001000,
      S_T5 = 6'b010000,
      S_T6 = 6'b100000
   } state_e;

`ifdef CTRL_SKIP_NOP_EN
   localparam bit SKIP_NOP = 1'b1;
`else
   localparam bit SKIP_NOP = 1'b0;
`endif

   // Control word bit order: Cp Ep nLm nCE nLi nEi nLa Ea Su Eu nLb nLo
   localparam logic [11:0] CON_IDLE    = 12'h3E3;
   localparam logic [11:0] CON_FETCH1  = 12'h5E3;
   localparam logic [11:0] CON_FETCH2  = 12'hBE3;
   localparam logic [11:0] CON_FETCH3  = 12'h263;
   localparam logic [11:0] CON_ADDR    = 12'h1A3;
   localparam logic [11:0] CON_LDA5    = 12'h2C3;
   localparam logic [11:0] CON_LDB5    = 12'h2E1;
   localparam logic [11:0] CON_ADD6    = 12'h3C7;
   localparam logic [11:0] CON_SUB6    = 12'h3CF;
   localparam logic [11:0] CON_OUT4    = 12'h3F2;

   state_e state_q;
   logic   halt_q;

   logic op_lda, op_add, op_sub, op_out, op_hlt, op_undef;

   always_comb begin
      op_lda   = (opcode == 4'h0);
      op_add   = (opcode == 4'h1);
      op_sub   = (opcode == 4'h2);
      op_out   = (opcode == 4'hE);
      op_hlt   = (opcode == 4'hF);
      op_undef = !(op_lda || op_add || op_sub || op_out || op_hlt);
   end

   // Opcode only steers transitions out of T4/T5, where the IR is already loaded.
   always_ff @(negedge CLK or posedge CLR) begin
      if (CLR) begin
         state_q <= S_T1;
         halt_q  <= 1'b0;
      end else if (!halt_q) begin
         unique case (state_q)
            S_T1: state_q <= S_T2;
            S_T2: state_q <= S_T3;
            S_T3: state_q <= S_T4;
            S_T4: begin
               if (op_hlt)
                  halt_q <= 1'b1;
               else if (SKIP_NOP && (op_out || op_undef))
                  state_q <= S_T1;
               else
                  state_q <= S_T5;
            end
            S_T5: begin
               if (SKIP_NOP && op_lda)
                  state_q <= S_T1;
               else
                  state_q <= S_T6;
            end
            default: state_q <= S_T1;
         endcase
      end
   end

   always_comb begin
      CON = CON_IDLE;
      if (!CLR && !halt_q) begin
         unique case (state_q)
            S_T1: CON = CON_FETCH1;
            S_T2: CON = CON_FETCH2;
            S_T3: CON = CON_FETCH3;
            S_T4: begin
               if (op_lda || op_add || op_sub) CON = CON_ADDR;
               else if (op_out)                CON = CON_OUT4;
            end
            S_T5: begin
               if (op_lda)                 CON = CON_LDA5;
               else if (op_add || op_sub)  CON = CON_LDB5;
            end
            S_T6: begin
               if (op_add)      CON = CON_ADD6;
               else if (op_sub) CON = CON_SUB6;
            end
            default: CON = CON_IDLE;
         endcase
      end
   end

   assign T   = state_q;
   assign HLT = !CLR && (halt_q || (state_q == S_T4 && op_hlt));

endmodule
